// File: rtl/riscv_pkg.sv
// Shared constants for the riscv_i core: opcodes, RAM base address,
// LOAD/STORE funct3 encodings and the load/store unit state type.
package riscv_pkg;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;

    localparam logic [31:0] ENTRY = 32'h8000_0000;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/m_load_extend.sv
// Combinational load data alignment and sign/zero extension: picks the
// addressed byte or halfword out of a RAM word and widens it to 32 bits.
module m_load_extend
    import riscv_pkg::*;
(
    input  logic [2:0]  fun3,
    input  logic [1:0]  a,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfwords only use a[1]; a[0] is ignored so misaligned halves read aligned.
    assign byte_sel = rdata[{a, 3'b000} +: 8];
    assign half_sel = rdata[{a[1], 4'b0000} +: 16];

    always_comb begin
        data = 32'h0;
        case (fun3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LW:   data = rdata;
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LHU:  data = {16'h0, half_sel};
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/m_lsu.sv
// Load/store unit: one word-wide access at a time on the unified RAM.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned LH/LHU/SH/LW/SW instead of forcing alignment.
module m_lsu #(
    parameter logic [31:0] ENTRY    = riscv_pkg::ENTRY,
    parameter int unsigned MEMWORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_fun3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_fault
);
    import riscv_pkg::*;

    lsu_state_t  state_reg;
    logic        store_reg;
    logic [2:0]  fun3_reg;
    logic [1:0]  a_reg;
    logic        req_ready_reg;
    logic        mem_valid_reg;
    logic        mem_we_reg;
    logic [3:0]  mem_be_reg;
    logic [11:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic        rsp_valid_reg;
    logic        rsp_fault_reg;
    logic [31:0] rsp_data_reg;

    logic [31:0] word_idx;
    logic        range_fault;
    logic        fun3_fault;
    logic        misalign_fault;
    logic        req_fault;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] load_data;

    // Addresses below ENTRY wrap to a huge index, so the range compare also catches them.
    assign word_idx    = (req_addr - ENTRY) >> 2;
    assign range_fault = (req_addr < ENTRY) || (word_idx >= MEMWORDS);
    assign fun3_fault  = req_store ? (req_fun3 >= 3'd3)
                                   : ((req_fun3 == 3'b011) || (req_fun3 == 3'b110) || (req_fun3 == 3'b111));

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        misalign_fault = 1'b0;
        case (req_fun3)
            F3_LH, F3_LHU: misalign_fault = req_addr[0];
            F3_LW:         misalign_fault = |req_addr[1:0];
            default:       misalign_fault = 1'b0;
        endcase
    end
`else
    assign misalign_fault = 1'b0;
`endif

    assign req_fault = range_fault || fun3_fault || misalign_fault;

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = req_wdata;
        if (req_store) begin
            case (req_fun3)
                F3_SB: begin
                    be_next    = 4'b0001 << req_addr[1:0];
                    wdata_next = {4{req_wdata[7:0]}};
                end
                F3_SH: begin
                    be_next    = 4'b0011 << {req_addr[1], 1'b0};
                    wdata_next = {2{req_wdata[15:0]}};
                end
                default: begin
                    be_next    = 4'b1111;
                    wdata_next = req_wdata;
                end
            endcase
        end
    end

    m_load_extend u_load_extend (
        .fun3  (fun3_reg),
        .a     (a_reg),
        .rdata (mem_rdata),
        .data  (load_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            store_reg     <= 1'b0;
            fun3_reg      <= 3'b000;
            a_reg         <= 2'b00;
            req_ready_reg <= 1'b1;
            mem_valid_reg <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_be_reg    <= 4'b0000;
            mem_addr_reg  <= 12'h000;
            mem_wdata_reg <= 32'h0;
            rsp_valid_reg <= 1'b0;
            rsp_fault_reg <= 1'b0;
            rsp_data_reg  <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        store_reg     <= req_store;
                        fun3_reg      <= req_fun3;
                        a_reg         <= req_addr[1:0];
                        req_ready_reg <= 1'b0;
                        rsp_data_reg  <= 32'h0;
                        if (req_fault) begin
                            rsp_fault_reg <= 1'b1;
                            rsp_valid_reg <= 1'b1;
                            state_reg     <= RESP;
                        end else begin
                            rsp_fault_reg <= 1'b0;
                            mem_valid_reg <= 1'b1;
                            mem_we_reg    <= req_store;
                            mem_be_reg    <= be_next;
                            mem_addr_reg  <= word_idx[11:0];
                            mem_wdata_reg <= wdata_next;
                            state_reg     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_valid_reg <= 1'b0;
                        if (store_reg) begin
                            rsp_valid_reg <= 1'b1;
                            state_reg     <= RESP;
                        end else begin
                            state_reg     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        rsp_data_reg  <= load_data;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid_reg <= 1'b0;
                    req_ready_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                    mem_valid_reg <= 1'b0;
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign mem_valid = mem_valid_reg;
    assign mem_we    = mem_we_reg;
    assign mem_be    = mem_be_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_fault = rsp_fault_reg;

endmodule

// File: tb/tb_m_lsu.sv
// Bench for m_lsu: a RAM responder with optional stalls, extra read latency and
// stray rvalid pulses, checked against a byte-level reference memory model.
module tb_m_lsu;

    localparam logic [31:0] ENTRY    = 32'h8000_0000;
    localparam int          MEMWORDS = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_fun3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        mem_valid;
    logic        mem_ready = 1'b1;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_fault;

    always #5 clk = ~clk;

    m_lsu #(.ENTRY(ENTRY), .MEMWORDS(MEMWORDS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_fun3(req_fun3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fault(rsp_fault)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ram     [MEMWORDS];
    logic [31:0] ref_mem [MEMWORDS];

    bit          stall_force = 0;
    bit          stall_rand  = 0;
    bit          spurious_en = 0;
    int          lat_max     = 0;
    bit          rd_pending  = 0;
    int          rd_delay    = 0;
    logic [11:0] rd_idx      = 12'h0;

    typedef struct {
        bit          fault;
        logic [31:0] data;
        int          rsp_cyc;
        int          mv_cyc;
        logic        we;
        logic [3:0]  be;
        logic [11:0] addr;
        logic [31:0] wdata;
        bit          stable_ok;
        bit          busy_ok;
        bit          idle_after;
    } res_t;

    typedef struct {
        bit          fault;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          idx;
    } exp_t;

    // RAM responder, driven away from the active edge. A command seen with
    // mem_ready high here is taken at the next rising edge.
    always @(negedge clk) begin
        if (rd_pending) begin
            if (rd_delay == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = ram[rd_idx];
                rd_pending = 0;
            end else begin
                rd_delay   = rd_delay - 1;
                mem_rvalid = 1'b0;
            end
        end else if (spurious_en && ($urandom_range(0, 3) == 0)) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
        end else begin
            mem_rvalid = 1'b0;
        end
        mem_ready = stall_force ? 1'b0 : (stall_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        if (reset && mem_valid && mem_ready) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
            end else begin
                rd_pending = 1;
                rd_delay   = (lat_max > 0) ? int'($urandom_range(0, lat_max)) : 0;
                rd_idx     = mem_addr;
            end
        end
    end

    // Reference model: decides fault, expected lane data/enables and load
    // result from the access rules; commits stores into ref_mem.
    task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output exp_t e);
        int          a;
        int          hb;
        logic [31:0] off;
        logic [31:0] word;
        logic [31:0] v;
        a   = int'(addr % 4);
        off = addr - ENTRY;
        e.fault = 0;
        if (addr < ENTRY) e.fault = 1;
        if (off / 4 >= MEMWORDS) e.fault = 1;
        if (st && f3 >= 3) e.fault = 1;
        if (!st && (f3 == 3 || f3 >= 6)) e.fault = 1;
`ifdef LSU_MISALIGN_CHECK_EN
        if ((f3 == 1 || f3 == 5) && (a % 2 == 1)) e.fault = 1;
        if (f3 == 2 && a != 0) e.fault = 1;
`endif
        e.data  = 32'h0;
        e.be    = 4'hF;
        e.wdata = wd;
        e.idx   = int'(off / 4);
        if (e.fault) return;
        word = ref_mem[e.idx];
        hb   = (a / 2) * 2;
        if (st) begin
            case (f3)
                3'd0: begin
                    e.wdata = {24'h0, wd[7:0]} * 32'h0101_0101;
                    e.be = 4'h0; e.be[a] = 1'b1;
                    ref_mem[e.idx] = (word & ~(32'hFF << (8*a))) | ({24'h0, wd[7:0]} << (8*a));
                end
                3'd1: begin
                    e.wdata = {16'h0, wd[15:0]} * 32'h0001_0001;
                    e.be = 4'h0; e.be[hb] = 1'b1; e.be[hb+1] = 1'b1;
                    ref_mem[e.idx] = (word & ~(32'hFFFF << (8*hb))) | ({16'h0, wd[15:0]} << (8*hb));
                end
                default: ref_mem[e.idx] = wd;
            endcase
        end else begin
            case (f3)
                3'd0, 3'd4: begin
                    v = (word >> (8*a)) & 32'hFF;
                    e.data = (f3 == 0 && v >= 128) ? v + 32'hFFFF_FF00 : v;
                end
                3'd1, 3'd5: begin
                    v = (word >> (8*hb)) & 32'hFFFF;
                    e.data = (f3 == 1 && v >= 32768) ? v + 32'hFFFF_0000 : v;
                end
                default: e.data = word;
            endcase
        end
    endtask

    // Drives one request and records what the DUT does until its response.
    task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input bit hold, output res_t r);
        int w;
        r.fault = 0; r.data = 32'h0; r.rsp_cyc = 0; r.mv_cyc = 0; r.we = 1'b0; r.be = 4'h0;
        r.addr = 12'h0; r.wdata = 32'h0; r.stable_ok = 1; r.busy_ok = 1; r.idle_after = 0;
        @(negedge clk);
        w = 0;
        while (req_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_wait: req_ready=%b after %0d cycles, required 1", req_ready, w);
            return;
        end
        req_valid = 1'b1; req_store = st; req_fun3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = hold; req_store = ~st; req_fun3 = f3 ^ 3'b010; req_addr = ~addr; req_wdata = ~wd;
        for (int c = 1; c <= 80 && r.rsp_cyc == 0; c++) begin
            @(negedge clk);
            if (mem_valid === 1'b1) begin
                if (r.mv_cyc == 0) begin
                    r.mv_cyc = c; r.we = mem_we; r.be = mem_be; r.addr = mem_addr; r.wdata = mem_wdata;
                end else if (mem_we !== r.we || mem_be !== r.be || mem_addr !== r.addr || mem_wdata !== r.wdata) begin
                    r.stable_ok = 0;
                end
            end
            if (req_ready !== 1'b0) r.busy_ok = 0;
            if (rsp_valid === 1'b1) begin
                r.rsp_cyc = c; r.fault = rsp_fault; r.data = rsp_data; req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        n_checks++;
        if (r.rsp_cyc == 0) begin
            n_fail++;
            $display("FAIL rsp_timeout: rsp_valid=%b after 80 cycles, required 1", rsp_valid);
            return;
        end
        @(negedge clk);
        r.idle_after = (req_ready === 1'b1) && (rsp_valid === 1'b0);
        $display("txn store=%0b f3=%0d addr=%h wdata=%h -> fault=%0b data=%h rsp_cyc=%0d",
                 st, f3, addr, wd, r.fault, r.data, r.rsp_cyc);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_req_ready: got %b, required 1", req_ready);
        end
        n_checks++;
        if ({mem_valid, mem_we, mem_be, mem_addr, mem_wdata, rsp_valid, rsp_fault, rsp_data} !== 84'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: mem_valid=%b we=%b be=%h addr=%h wdata=%h rsp_valid=%b fault=%b data=%h, required all 0",
                     mem_valid, mem_we, mem_be, mem_addr, mem_wdata, rsp_valid, rsp_fault, rsp_data);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store();
        exp_t e; res_t r;
        model(1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, e);
        do_txn(1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, r);
        n_checks++;
        if (r.mv_cyc !== 1 || r.addr !== 12'd4 || r.be !== 4'hF || r.we !== 1'b1 || r.wdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL sw_cmd: cyc=%0d addr=%0d be=%b we=%b wdata=%h, required cyc=1 addr=4 be=1111 we=1 wdata=deadbeef",
                     r.mv_cyc, r.addr, r.be, r.we, r.wdata);
        end
        n_checks++;
        if (r.rsp_cyc !== 2 || r.fault !== 1'b0 || r.data !== 32'h0) begin
            n_fail++;
            $display("FAIL sw_rsp: cyc=%0d fault=%b data=%h, required cyc=2 fault=0 data=0", r.rsp_cyc, r.fault, r.data);
        end
        n_checks++;
        if (!(r.busy_ok && r.idle_after)) begin
            n_fail++; $display("FAIL sw_ready: busy_ok=%0b idle_after=%0b, required 1 1", r.busy_ok, r.idle_after);
        end
        model(1'b1, 3'b000, 32'h8000_0013, 32'h0000_00A5, e);
        do_txn(1'b1, 3'b000, 32'h8000_0013, 32'h0000_00A5, 1'b0, r);
        n_checks++;
        if (r.be !== 4'b1000 || r.wdata !== 32'hA5A5_A5A5 || r.addr !== 12'd4 || r.rsp_cyc !== 2) begin
            n_fail++;
            $display("FAIL sb_cmd: be=%b wdata=%h addr=%0d rsp_cyc=%0d, required be=1000 wdata=a5a5a5a5 addr=4 rsp_cyc=2",
                     r.be, r.wdata, r.addr, r.rsp_cyc);
        end
    endtask

    task automatic test_load_extend();
        exp_t e; res_t r;
        logic [31:0] want [5];
        logic [2:0]  f3s  [5];
        logic [31:0] adrs [5];
        want = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01};
        f3s  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        adrs = '{32'h8000_0012, 32'h8000_0013, 32'h8000_0012, 32'h8000_0012, 32'h8000_0010};
        ram[4] = 32'h80FF_7F01;
        ref_mem[4] = 32'h80FF_7F01;
        for (int i = 0; i < 5; i++) begin
            model(1'b0, f3s[i], adrs[i], 32'h0, e);
            do_txn(1'b0, f3s[i], adrs[i], 32'h0, 1'b0, r);
            n_checks++;
            if (r.data !== want[i] || r.fault !== 1'b0) begin
                n_fail++;
                $display("FAIL load_ext[%0d]: data=%h fault=%b, required data=%h fault=0", i, r.data, r.fault, want[i]);
            end
            n_checks++;
            if (r.rsp_cyc !== 3 || r.mv_cyc !== 1 || r.we !== 1'b0 || r.be !== 4'hF || r.addr !== 12'd4) begin
                n_fail++;
                $display("FAIL load_timing[%0d]: rsp_cyc=%0d mv_cyc=%0d we=%b be=%b addr=%0d, required 3 1 0 1111 4",
                         i, r.rsp_cyc, r.mv_cyc, r.we, r.be, r.addr);
            end
        end
    endtask

    task automatic test_fault();
        exp_t e; res_t r;
        logic [31:0] adrs [5];
        logic [2:0]  f3s  [5];
        bit          sts  [5];
        bit          flt  [5];
        adrs = '{32'h7FFF_FFFC, ENTRY + 32'(MEMWORDS*4) - 32'd4, ENTRY + 32'(MEMWORDS*4), 32'h8000_0008, 32'h8000_0008};
        f3s  = '{3'b010, 3'b010, 3'b010, 3'b011, 3'b100};
        sts  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        flt  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            model(sts[i], f3s[i], adrs[i], 32'h1357_9BDF, e);
            do_txn(sts[i], f3s[i], adrs[i], 32'h1357_9BDF, 1'b0, r);
            n_checks++;
            if (r.fault !== flt[i]) begin
                n_fail++; $display("FAIL fault_flag[%0d]: fault=%b, required %b", i, r.fault, flt[i]);
            end
            n_checks++;
            if (flt[i] && (r.rsp_cyc !== 1 || r.mv_cyc !== 0 || r.data !== 32'h0)) begin
                n_fail++;
                $display("FAIL fault_rsp[%0d]: rsp_cyc=%0d mv_cyc=%0d data=%h, required 1 0 0", i, r.rsp_cyc, r.mv_cyc, r.data);
            end else if (!flt[i] && (r.data !== e.data || r.addr !== 12'(MEMWORDS - 1))) begin
                n_fail++;
                $display("FAIL edge_load[%0d]: data=%h addr=%0d, required %h %0d", i, r.data, r.addr, e.data, MEMWORDS - 1);
            end
        end
    endtask

    task automatic test_misalign();
        exp_t e; res_t r;
        model(1'b0, 3'b010, 32'h8000_0006, 32'h0, e);
        do_txn(1'b0, 3'b010, 32'h8000_0006, 32'h0, 1'b0, r);
        n_checks++;
`ifdef LSU_MISALIGN_CHECK_EN
        if (r.fault !== 1'b1 || r.mv_cyc !== 0) begin
            n_fail++; $display("FAIL lw_misalign: fault=%b mv_cyc=%0d, required 1 0", r.fault, r.mv_cyc);
        end
`else
        if (r.fault !== 1'b0 || r.addr !== 12'd1 || r.data !== ref_mem[1]) begin
            n_fail++;
            $display("FAIL lw_misalign: fault=%b addr=%0d data=%h, required 0 1 %h", r.fault, r.addr, r.data, ref_mem[1]);
        end
`endif
        model(1'b1, 3'b001, 32'h8000_0003, 32'hCAFE_1234, e);
        do_txn(1'b1, 3'b001, 32'h8000_0003, 32'hCAFE_1234, 1'b0, r);
        n_checks++;
`ifdef LSU_MISALIGN_CHECK_EN
        if (r.fault !== 1'b1 || r.mv_cyc !== 0) begin
            n_fail++; $display("FAIL sh_misalign: fault=%b mv_cyc=%0d, required 1 0", r.fault, r.mv_cyc);
        end
`else
        if (r.fault !== 1'b0 || r.be !== 4'b1100 || r.wdata !== 32'h1234_1234) begin
            n_fail++; $display("FAIL sh_misalign: fault=%b be=%b wdata=%h, required 0 1100 12341234", r.fault, r.be, r.wdata);
        end
`endif
    endtask

    task automatic test_stall_reset();
        exp_t e; res_t r;
        logic [3:0]  be0;
        logic [11:0] a0;
        logic [31:0] w0;
        bit          stable;
        bit          quiet;
        int          w;
        be0 = 4'h0; a0 = 12'h0; w0 = 32'h0;
        stall_force = 1;
        @(negedge clk);
        w = 0;
        while (req_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        req_valid = 1'b1; req_store = 1'b1; req_fun3 = 3'b010; req_addr = 32'h8000_0020; req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        stable = 1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) begin be0 = mem_be; a0 = mem_addr; w0 = mem_wdata; end
            if (mem_valid !== 1'b1 || mem_be !== be0 || mem_addr !== a0 || mem_wdata !== w0 || rsp_valid !== 1'b0)
                stable = 0;
        end
        n_checks++;
        if (!stable) begin
            n_fail++; $display("FAIL stall_hold: mem_valid=%b rsp_valid=%b, required held command and no response", mem_valid, rsp_valid);
        end
        n_checks++;
        if (a0 !== 12'd8 || be0 !== 4'hF || w0 !== 32'h1234_5678) begin
            n_fail++; $display("FAIL stall_cmd: addr=%0d be=%b wdata=%h, required 8 1111 12345678", a0, be0, w0);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (mem_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL async_reset: mem_valid=%b req_ready=%b, required 0 1", mem_valid, req_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        stall_force = 0;
        quiet = 1;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || mem_valid !== 1'b0 || req_ready !== 1'b1) quiet = 0;
        end
        n_checks++;
        if (!quiet) begin
            n_fail++; $display("FAIL post_reset_idle: rsp_valid=%b mem_valid=%b req_ready=%b, required 0 0 1", rsp_valid, mem_valid, req_ready);
        end
        model(1'b0, 3'b010, 32'h8000_0020, 32'h0, e);
        do_txn(1'b0, 3'b010, 32'h8000_0020, 32'h0, 1'b0, r);
        n_checks++;
        if (r.data !== e.data) begin
            n_fail++; $display("FAIL abandoned_store: data=%h, required %h", r.data, e.data);
        end
    endtask

    task automatic test_random();
        exp_t        e;
        res_t        r;
        bit          st;
        bit          hold;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  ld_f3 [5];
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        stall_rand = 1; lat_max = 3; spurious_en = 1;
        for (int i = 0; i < 200; i++) begin
            st   = 1'($urandom_range(0, 1));
            hold = 1'($urandom_range(0, 1));
            wd   = $urandom;
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            else if (st)                   f3 = 3'($urandom_range(0, 2));
            else                           f3 = ld_f3[$urandom_range(0, 4)];
            case ($urandom_range(0, 9))
                0:       addr = ENTRY - 32'($urandom_range(1, 16));
                1:       addr = ENTRY + 32'(MEMWORDS*4) - 32'd8 + 32'($urandom_range(0, 15));
                2:       addr = $urandom;
                default: addr = ENTRY + 32'($urandom_range(0, 63));
            endcase
            model(st, f3, addr, wd, e);
            do_txn(st, f3, addr, wd, hold, r);
            n_checks++;
            if (r.fault !== e.fault || r.data !== e.data) begin
                n_fail++;
                $display("FAIL rand_rsp[%0d]: fault=%b data=%h, required fault=%b data=%h", i, r.fault, r.data, e.fault, e.data);
            end
            n_checks++;
            if ((r.mv_cyc != 0) !== !e.fault || !(r.stable_ok && r.busy_ok && r.idle_after)) begin
                n_fail++;
                $display("FAIL rand_handshake[%0d]: mv_cyc=%0d stable=%0b busy=%0b idle=%0b, required traffic=%0b 1 1 1",
                         i, r.mv_cyc, r.stable_ok, r.busy_ok, r.idle_after, !e.fault);
            end
            if (!e.fault) begin
                n_checks++;
                if (r.we !== st || r.be !== e.be || r.addr !== 12'(e.idx) || (st && r.wdata !== e.wdata)) begin
                    n_fail++;
                    $display("FAIL rand_cmd[%0d]: we=%b be=%b addr=%0d wdata=%h, required %b %b %0d %h",
                             i, r.we, r.be, r.addr, r.wdata, st, e.be, e.idx, e.wdata);
                end
            end
        end
        stall_rand = 0; lat_max = 0; spurious_en = 0;
        for (int i = 0; i < 16; i++) begin
            model(1'b0, 3'b010, ENTRY + 32'(i*4), 32'h0, e);
            do_txn(1'b0, 3'b010, ENTRY + 32'(i*4), 32'h0, 1'b0, r);
            n_checks++;
            if (r.data !== ref_mem[i]) begin
                n_fail++; $display("FAIL sweep[%0d]: data=%h, required %h", i, r.data, ref_mem[i]);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        for (int i = 0; i < MEMWORDS; i++) begin
            v = $urandom;
            ram[i] = v;
            ref_mem[i] = v;
        end
        test_reset();
        test_store();
        test_load_extend();
        test_fault();
        test_misalign();
        test_stall_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/m_lsu.md
# m_lsu

Load/store unit for the `riscv_i` core: the memory-access stage directly downstream of the execute/arith stage. It takes the effective address produced by the `fun3 = 000` adder, together with the LOAD/STORE `fun3` and the `rs2` value, and runs a word-wide access on the unified instruction/data RAM. It returns sign- or zero-extended load data, or a completion pulse for stores, to the writeback step. It replaces the unimplemented "LOAD/STORE from memory later" paths in the core.

## Interface
- `ENTRY`, default `32'h8000_0000`: byte address of RAM word 0.
- `MEMWORDS`, default `4096`: RAM depth in 32-bit words.
- `clk` in, 1: clock. All state changes on the rising edge.
- `reset` in, 1: reset, asynchronous, active-low.
- `req_valid` in, 1: request present.
- `req_ready` out, 1: unit can accept a request. High only in IDLE.
- `req_store` in, 1: 1 = STORE, 0 = LOAD.
- `req_fun3` in, 3: RISC-V funct3.
- `req_addr` in, 32: effective byte address.
- `req_wdata` in, 32: store data (the `rs2` value).
- `mem_valid` out, 1: memory command valid.
- `mem_ready` in, 1: memory accepts the command this cycle.
- `mem_we` out, 1: write command.
- `mem_be` out, 4: byte enables.
- `mem_addr` out, 12: word index, `(req_addr - ENTRY) >> 2`.
- `mem_wdata` out, 32: lane-replicated write data.
- `mem_rvalid` in, 1: read data valid.
- `mem_rdata` in, 32: read data.
- `rsp_valid` out, 1: one-cycle completion pulse.
- `rsp_data` out, 32: extended load data. Zero for stores and faults.
- `rsp_fault` out, 1: access fault. Qualified by `rsp_valid`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- All outputs reset to 0, except `req_ready`, which resets to 1.
- IDLE:
  - A request is accepted when `req_valid && req_ready`.
  - All request fields are latched on acceptance.
  - The request is checked. It faults if any of the following holds:
    - the address is below `ENTRY`, or the word index is `>= MEMWORDS`;
    - a load uses `fun3` 011, 110 or 111;
    - a store uses `fun3 >= 3`.
  - A faulting request goes to RESP with `rsp_fault = 1` and issues no memory command. Otherwise the FSM goes to ISSUE.
- ISSUE:
  - `mem_valid` is held high with stable `mem_we`, `mem_be`, `mem_addr` and `mem_wdata` until `mem_ready`.
  - On `mem_ready`, a store goes to RESP and a load goes to WAIT.
- WAIT: on `mem_rvalid`, `mem_rdata` is captured and extended, then the FSM goes to RESP.
- RESP: `rsp_valid = 1` for exactly one cycle, then IDLE.
- Byte enables and write data, with `a = addr[1:0]`:
  - SB: `be = 0001 << a`, `wdata = {4{d[7:0]}}`.
  - SH: `be = 0011 << {a[1], 1'b0}`, `wdata = {2{d[15:0]}}`.
  - SW: `be = 1111`, `wdata = d`.
  - Loads: `be = 1111`, `we = 0`.
- Load extension:
  - `w = rdata >> (8*a)` for byte accesses, and `rdata >> (16*a[1])` for halfword accesses.
  - LB and LH sign-extend `w[7:0]` / `w[15:0]`.
  - LBU and LHU zero-extend.
  - LW passes `rdata` through.
- Address arithmetic is 32-bit unsigned and wraps modulo 2^32. An address below `ENTRY` therefore produces a large index and faults through the range check.
- `req_valid` while not IDLE is ignored; `req_ready` is 0 in that case.
- Spurious `mem_rvalid` outside WAIT is ignored.
- `reset` asserted mid-access: the FSM returns to IDLE and `mem_valid` drops immediately (asynchronously). A pending response is lost. The memory must tolerate an abandoned command.

## Timing
- Acceptance is at edge 0.
- Fault: `rsp_valid` at cycle 1.
- Store with `mem_ready` already high: `mem_valid` in cycle 1, `rsp_valid` in cycle 2.
- Load with a 1-cycle RAM: `mem_valid` in cycle 1, `mem_rvalid` in cycle 2, `rsp_valid` in cycle 3.
- Each cycle of `mem_ready = 0` adds one cycle, as does each extra cycle of read latency.
- Throughput is one request per response plus one IDLE cycle. There is no pipelining.
- `rsp_data` and `rsp_fault` are registered and stable while `rsp_valid` is high.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined: the following also fault, with no memory access:
  - LH, LHU and SH with `addr[0] = 1`;
  - LW and SW with `addr[1:0] != 0`.
- Macro undefined: low address bits below the access size are ignored and the access is forced aligned. Example: LW at `0x8000_0006` reads word index 1.

## Structure
- Shared package `riscv_pkg` holds:
  - the opcode constants (`LOAD`, `STORE`, etc.);
  - `ENTRY`;
  - funct3 constants for LB/LH/LW/LBU/LHU and SB/SH/SW;
  - the FSM state enum.
- Sub-module `m_load_extend` is purely combinational, with inputs `fun3`, `a[1:0]` and `rdata`, and output `data`. It is instantiated once, with its output registered into `rsp_data` on the WAIT→RESP transition.

## Test plan
- SW `0x8000_0010`, data `0xDEADBEEF`, `mem_ready = 1` → cycle 1: `mem_addr = 4`, `be = 1111`, `we = 1`; cycle 2: `rsp_valid`, `rsp_fault = 0`.
- SB `0x8000_0013`, data `0x0000_00A5` → `be = 1000`, `wdata = 0xA5A5_A5A5`.
- RAM word 4 = `0x80FF_7F01`:
  - LB `0x8000_0012` → `rsp_data = 0xFFFF_FFFF`;
  - LBU `0x8000_0013` → `0x0000_0080`;
  - LH `0x8000_0012` → `0xFFFF_80FF`;
  - rsp at cycle 3.
- LW `0x7FFF_FFFC` → `rsp_fault = 1` at cycle 1, `mem_valid` never asserted.
- LW `0x8000_0006` → with macro: fault; without macro: reads index 1.
- `mem_ready` held low for 3 cycles during a store, then `reset` pulsed low → `mem_valid` stable while waiting, drops at reset, and the unit returns to IDLE with `req_ready = 1` and no `rsp_valid`.
